// File: rtl/tick_prescaler.sv
// Programmable tick prescaler: divides clk down to a one-cycle tick, with a square
// wave, a wrapping tick counter and a cascade carry. Divisor changes take effect at a wrap or on clr.
module tick_prescaler #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned WIDTH   = 26,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  output logic             tick,
  output logic             sq,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             carry,
  output logic             load_err
);

  // The divisor guard keeps the expression legal so the TICK_HZ check below can fire.
  localparam longint unsigned DIV0_L =
    longint'(CLK_HZ / ((TICK_HZ == 0) ? 1 : TICK_HZ)) & ((TICK_HZ == 0) ? 64'd0 : ~64'd0);
  localparam logic [WIDTH-1:0] DIV0  = WIDTH'(DIV0_L);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  if (TICK_HZ == 0) begin : g_bad_tick_hz
    $error("tick_prescaler: TICK_HZ must be nonzero");
  end
  if (DIV0_L == 0) begin : g_bad_div0_zero
    $error("tick_prescaler: CLK_HZ/TICK_HZ must be at least 1");
  end
  if (DIV0_L >= (64'd1 << WIDTH)) begin : g_bad_div0_wide
    $error("tick_prescaler: CLK_HZ/TICK_HZ does not fit in WIDTH bits");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             carry_q, carry_d;
  logic             load_err_q, load_err_d;

  logic terminal;
  logic load_ok;
  logic load_bad;

  assign load_ok  = div_load && (div_val != '0);
  assign load_bad = div_load && (div_val == '0);
  assign terminal = en && (count_q == (act_q - ONE_W));

  always_comb begin
    count_d      = count_q;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    tick_d       = 1'b0;
    sq_d         = sq_q;
    tick_cnt_d   = tick_cnt_q;
    carry_d      = 1'b0;
    load_err_d   = load_bad;

    if (clr) begin
      count_d = '0;
      if (pend_valid_q) begin
        act_d        = pend_q;
        pend_valid_d = 1'b0;
      end
    end else if (terminal) begin
      count_d    = '0;
      tick_d     = 1'b1;
      sq_d       = ~sq_q;
      tick_cnt_d = tick_cnt_q + ONE_C;
      carry_d    = (tick_cnt_q == '1);
      if (pend_valid_q) begin
        act_d        = pend_q;
        pend_valid_d = 1'b0;
      end
    end else if (en) begin
      count_d = count_q + ONE_W;
    end

    // A load on the same edge as an apply becomes the next pending divisor.
    if (load_ok) begin
      pend_d       = div_val;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q      <= '0;
      act_q        <= DIV0;
      pend_q       <= DIV0;
      pend_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      sq_q         <= 1'b0;
      tick_cnt_q   <= '0;
      carry_q      <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      tick_q       <= tick_d;
      sq_q         <= sq_d;
      tick_cnt_q   <= tick_cnt_d;
      carry_q      <= carry_d;
      load_err_q   <= load_err_d;
    end
  end

  assign tick     = tick_q;
  assign sq       = sq_q;
  assign tick_cnt = tick_cnt_q;
  assign carry    = carry_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// Bench for tick_prescaler (DIV0=10, CNT_W=2): per-edge scoreboard against a behavioural
// model, plus directed tick-timing scenarios with hard-coded expected edge numbers.
module tb_tick_prescaler;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int OUT_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic             div_load = 1'b0;
  logic [WIDTH-1:0] div_val = '0;
  logic             tick;
  logic             sq;
  logic [CNT_W-1:0] tick_cnt;
  logic             carry;
  logic             load_err;

  tick_prescaler #(
    .CLK_HZ (10),
    .TICK_HZ(1),
    .WIDTH  (WIDTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .div_load(div_load),
    .div_val (div_val),
    .tick    (tick),
    .sq      (sq),
    .tick_cnt(tick_cnt),
    .carry   (carry),
    .load_err(load_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [OUT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int ec       = 0;
  int tick_e[$];
  int tick_sq[$];
  int tick_cn[$];
  int tick_cy[$];
  int exp_t[$];

  // reference model of the prescaler
  logic [WIDTH-1:0] m_count, m_act, m_pend;
  logic             m_pv, m_tick, m_sq, m_carry, m_lerr;
  logic [CNT_W-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ec);
    else n_pass++;
  endtask

  task automatic model_edge();
    logic term;
    if (!rst) begin
      m_count = '0; m_act = 8'd10; m_pend = 8'd10; m_pv = 1'b0;
      m_tick = 1'b0; m_sq = 1'b0; m_cnt = '0; m_carry = 1'b0; m_lerr = 1'b0;
    end else begin
      term   = en && (int'(m_count) == int'(m_act) - 1);
      m_lerr = div_load && (div_val == 0);
      m_tick = 1'b0;
      m_carry = 1'b0;
      if (clr) begin
        m_count = '0;
        if (m_pv) begin m_act = m_pend; m_pv = 1'b0; end
      end else if (term) begin
        m_count = '0;
        m_tick  = 1'b1;
        m_sq    = ~m_sq;
        m_carry = (m_cnt == 2'd3);
        m_cnt   = m_cnt + 2'd1;
        if (m_pv) begin m_act = m_pend; m_pv = 1'b0; end
      end else if (en) begin
        m_count = m_count + 8'd1;
      end
      if (div_load && div_val != 0) begin m_pend = div_val; m_pv = 1'b1; end
    end
  endtask

  // driver: one clock edge, model predicts, DUT sampled 1ns after the edge
  task automatic step();
    logic [OUT_W-1:0] got;
    model_edge();
    exp_q.push_back({m_tick, m_sq, m_cnt, m_carry, m_lerr});
    @(posedge clk);
    #1;
    ec++;
    got = {tick, sq, tick_cnt, carry, load_err};
    if (exp_q.size() == 0) check("sb_empty", 1, 0);
    else check("outs", 32'(got), 32'(exp_q.pop_front()));
    if (tick === 1'b1) begin
      tick_e.push_back(ec);
      tick_sq.push_back(int'(sq));
      tick_cn.push_back(int'(tick_cnt));
      tick_cy.push_back(int'(carry));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int v);
    div_load = 1'b1;
    div_val  = WIDTH'(v);
    step();
    div_load = 1'b0;
    div_val  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; clr = 1'b0; div_load = 1'b0; div_val = '0;
    run(2);
    rst = 1'b1;
    ec = 0;
    tick_e.delete(); tick_sq.delete(); tick_cn.delete(); tick_cy.delete();
  endtask

  task automatic check_ticks(input string tag);
    check({tag, "_n"}, 32'(tick_e.size()), 32'(exp_t.size()));
    for (int i = 0; i < exp_t.size() && i < tick_e.size(); i++)
      check({tag, "_edge"}, 32'(tick_e[i]), 32'(exp_t[i]));
  endtask

  initial begin
    // reset state and basic period with wrap/carry
    do_reset();
    check("rst_outs", 32'({tick, sq, tick_cnt, carry, load_err}), 32'(0));
    en = 1'b1;
    run(40);
    exp_t = '{10, 20, 30, 40};
    check_ticks("basic");
    if (tick_e.size() == 4) begin
      check("basic_sq0", 32'(tick_sq[0]), 1); check("basic_sq1", 32'(tick_sq[1]), 0);
      check("basic_sq2", 32'(tick_sq[2]), 1); check("basic_sq3", 32'(tick_sq[3]), 0);
      check("basic_cn0", 32'(tick_cn[0]), 1); check("basic_cn1", 32'(tick_cn[1]), 2);
      check("basic_cn2", 32'(tick_cn[2]), 3); check("basic_cn3", 32'(tick_cn[3]), 0);
      check("basic_cy0", 32'(tick_cy[0]), 0); check("basic_cy1", 32'(tick_cy[1]), 0);
      check("basic_cy2", 32'(tick_cy[2]), 0); check("basic_cy3", 32'(tick_cy[3]), 1);
    end

    // pause for 5 cycles at count 3
    do_reset();
    en = 1'b1;
    run(3);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(7);
    exp_t = '{15};
    check_ticks("pause");

    // load 4 at count 2: applies at the next wrap
    do_reset();
    en = 1'b1;
    run(2);
    load(4);
    run(15);
    exp_t = '{10, 14, 18};
    check_ticks("load4");

    // rejected load of 0, then a valid load of 5
    do_reset();
    en = 1'b1;
    run(2);
    load(0);
    check("lerr_hi", 32'(load_err), 1);
    step();
    check("lerr_lo", 32'(load_err), 0);
    run(16);
    load(5);
    run(14);
    exp_t = '{10, 20, 30, 35};
    check_ticks("lerr");

    // load 3 then clr at count 6: immediate apply, sq/tick_cnt held
    do_reset();
    en = 1'b1;
    run(10);
    load(3);
    run(5);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_sq", 32'(sq), 1);
    check("clr_cnt", 32'(tick_cnt), 1);
    check("clr_tick", 32'(tick), 0);
    run(9);
    exp_t = '{10, 20, 23, 26};
    check_ticks("clr");

    // reset mid-period with a load pending: pending load is discarded
    do_reset();
    en = 1'b1;
    run(1);
    load(4);
    run(5);
    rst = 1'b0;
    step();
    check("rst_mid", 32'({tick, sq, tick_cnt, carry, load_err}), 32'(0));
    rst = 1'b1;
    ec = 0;
    tick_e.delete(); tick_sq.delete(); tick_cn.delete(); tick_cy.delete();
    run(20);
    exp_t = '{10, 20};
    check_ticks("rst_pend");

    // divisor 1: tick every cycle, sq toggles every cycle
    do_reset();
    en = 1'b1;
    load(1);
    run(9);
    for (int e = 11; e <= 18; e++) begin
      step();
      check("div1_tick", 32'(tick), 1);
      check("div1_sq", 32'(sq), 32'((e % 2) == 0));
    end

    // random mix of enable, clear and loads against the model
    do_reset();
    en = 1'b1;
    load(3);
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      clr      = ($urandom_range(0, 24) == 0);
      div_load = ($urandom_range(0, 14) == 0);
      div_val  = WIDTH'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) rst = 1'b0;
      else rst = 1'b1;
      step();
    end
    rst = 1'b1; en = 1'b0; clr = 1'b0; div_load = 1'b0;
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tick_prescaler.md
TICK_PRESCALER -- requirements
Module: tick_prescaler

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000: input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1: reset-time tick rate in Hz. DIV0 = CLK_HZ/TICK_HZ (integer division).
REQ-003 SHALL have parameter WIDTH, default 26: divisor and count register width.
REQ-004 SHALL have parameter CNT_W, default 8: tick event counter width.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port en, input, 1: count enable; 0 = pause.
REQ-008 SHALL have port clr, input, 1: synchronous restart of the current period.
REQ-009 SHALL have port div_load, input, 1: load request for a new divisor.
REQ-010 SHALL have port div_val, input, WIDTH: requested divisor, in cycles per tick.
REQ-011 SHALL have port tick, output, 1: registered one-cycle pulse, once per period.
REQ-012 SHALL have port sq, output, 1: registered square wave; toggles on every tick event.
REQ-013 SHALL have port tick_cnt, output, CNT_W: number of tick events, wrapping.
REQ-014 SHALL have port carry, output, 1: registered pulse when tick_cnt wraps, for the next cascaded stage.
REQ-015 SHALL have port load_err, output, 1: registered one-cycle pulse when a load is rejected.

Function
REQ-016 SHALL hold three registers: count, active divisor (act) and pending divisor (pend), each WIDTH bits wide, plus a pend_valid flag.
REQ-017 SHALL, on each rising edge with en=1, increment count. Terminal event: count==act-1 with en=1; on that edge count SHALL become 0.
REQ-018 SHALL drive tick=1 for exactly the one cycle following a terminal edge, and tick=0 otherwise. Period: exactly act enabled cycles.
REQ-019 SHALL, on a terminal edge, toggle sq and increment tick_cnt modulo 2^CNT_W.
REQ-020 SHALL, on the terminal edge where tick_cnt goes from 2^CNT_W-1 to 0, drive carry=1 in the same cycle as that tick.
REQ-021 SHALL, while en=0, hold count, sq and tick_cnt, and drive tick=0 and carry=0.
REQ-022 SHALL, on div_load=1 with div_val>=1, set pend<=div_val and pend_valid<=1; a later load before apply overwrites pend.
REQ-023 SHALL, on div_load=1 with div_val==0, leave pend, pend_valid and act unchanged and drive load_err=1 for one cycle.
REQ-024 SHALL, on a terminal edge with pend_valid=1, set act<=pend (the value held before that edge) and clear pend_valid. A load arriving on that same edge becomes the new pending value.
REQ-025 SHALL, on clr=1 (any en), set count<=0 and tick<=0 and carry<=0, apply the pending divisor immediately if valid, and hold sq and tick_cnt. A div_load on that same edge SHALL be captured as pending for the next wrap.
REQ-026 SHALL use priority rst > clr > terminal/increment.
REQ-027 SHALL, when act==1, produce a terminal event on every enabled edge: tick held high continuously and sq toggling every cycle.
REQ-028 SHALL never let count exceed act-1; act changes only at a wrap, on clr, or on reset.
REQ-029 SHALL fail elaboration if TICK_HZ==0, DIV0==0, or DIV0>=2^WIDTH.

Reset
REQ-030 SHALL, on any edge with rst=0, set: count=0, act=DIV0, pend=DIV0, pend_valid=0, tick=0, sq=0, tick_cnt=0, carry=0, load_err=0.
REQ-031 SHALL apply reset mid-period or mid-load with the same result as REQ-030; a pending load is discarded.
REQ-032 SHALL, after rst returns high with en=1, produce the first tick in the cycle after the DIV0-th enabled edge.

Verification (CLK_HZ=10, TICK_HZ=1, CNT_W=2, so DIV0=10)
REQ-033 Release reset, en=1 held -> tick after edges 10, 20, 30, 40; sq = 1, 0, 1, 0; tick_cnt = 1, 2, 3, 0; carry only with the 4th tick.
REQ-034 en=0 for 5 cycles at count=3 -> tick delayed 5 cycles (after edge 15); no tick while paused.
REQ-035 div_load with div_val=4 at count=2 -> next tick still after edge 10; then ticks every 4 cycles (14, 18, ...).
REQ-036 div_load with div_val=0 -> load_err high for one cycle; period stays 10; a later valid load still works.
REQ-037 Load div_val=3, then clr at count=6 -> count=0 and act=3; ticks after 3, 6, 9 cycles; sq and tick_cnt unchanged by clr.
REQ-038 rst=0 at count=7 with a load pending -> all outputs 0 on the next cycle; period 10 resumes. Separately, div_val=1 -> tick high every cycle, sq toggling every cycle.
